// File: rtl/tpose_pingpong_ctrl.sv
// tpose_pingpong_ctrl: sequencing for two 8x8-byte transpose RAM banks.
// Rows fill the bank in write mode while the other bank drains as columns.
// Only control leaves this block; row and column data bypass it.
module tpose_pingpong_ctrl #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_sel,
    output logic              ram0_rnw,
    output logic              ram1_rnw,
    output logic              ram0_din_valid,
    output logic              ram1_din_valid,
    output logic [ADDR_W-1:0] wa,
    output logic [ADDR_W-1:0] ra,
    output logic [7:0]        be,
    output logic [1:0]        full_cnt
);

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    bank_state_t       state0_r, state1_r;
    bank_state_t       state0_nxt_s, state1_nxt_s;
    bank_state_t       wstate_s, rstate_s;
    logic              wb_r, rb_r;
    logic [ADDR_W-1:0] wcnt_r, rcnt_r, ra_r;
    logic              out_valid_r, out_sel_r, out_last_r;
    logic              in_ready_s, wr_s, issue_s, wr_last_s, rd_last_s;

    // Per-bank transition: a bank only moves on its own write or column issue.
    function automatic bank_state_t bank_next(input bank_state_t cur,
                                              input logic wr_here,
                                              input logic wr_last,
                                              input logic rd_here,
                                              input logic rd_last);
        bank_state_t nxt;
        nxt = cur;
        case (cur)
            BANK_EMPTY: if (wr_here)            nxt = BANK_FILL;  else nxt = BANK_EMPTY;
            BANK_FILL:  if (wr_here && wr_last) nxt = BANK_FULL;  else nxt = BANK_FILL;
            BANK_FULL:  if (rd_here)            nxt = BANK_DRAIN; else nxt = BANK_FULL;
            BANK_DRAIN: if (rd_here && rd_last) nxt = BANK_EMPTY; else nxt = BANK_DRAIN;
            default:                            nxt = BANK_EMPTY;
        endcase
        return nxt;
    endfunction

    // Handshake and issue decode from the pointed-to bank states.
    always_comb begin
        wstate_s   = wb_r ? state1_r : state0_r;
        rstate_s   = rb_r ? state1_r : state0_r;
        in_ready_s = (wstate_s == BANK_EMPTY) || (wstate_s == BANK_FILL);
        wr_s       = in_valid && in_ready_s;
        issue_s    = ((rstate_s == BANK_FULL) || (rstate_s == BANK_DRAIN)) &&
                     (!out_valid_r || out_ready);
        wr_last_s  = wr_s && (wcnt_r == LAST_IDX);
        rd_last_s  = issue_s && (rcnt_r == LAST_IDX);
    end

    // Next-state for both banks; write and read never hit the same bank.
    always_comb begin
        state0_nxt_s = state0_r;
        state1_nxt_s = state1_r;
        state0_nxt_s = bank_next(state0_r, wr_s && !wb_r, wr_last_s, issue_s && !rb_r, rd_last_s);
        state1_nxt_s = bank_next(state1_r, wr_s &&  wb_r, wr_last_s, issue_s &&  rb_r, rd_last_s);
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0_r <= BANK_EMPTY;
            state1_r <= BANK_EMPTY;
        end else begin
            state0_r <= state0_nxt_s;
            state1_r <= state1_nxt_s;
        end
    end

    // Bank pointers, row/column counters and the last issued column index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_r   <= 1'b0;
            rb_r   <= 1'b0;
            wcnt_r <= '0;
            rcnt_r <= '0;
            ra_r   <= '0;
        end else begin
            if (wr_s) begin
                wcnt_r <= wcnt_r + IDX_ONE;
                if (wr_last_s) begin
                    wb_r <= ~wb_r;
                end
            end
            if (issue_s) begin
                rcnt_r <= rcnt_r + IDX_ONE;
                ra_r   <= rcnt_r;
                if (rd_last_s) begin
                    rb_r <= ~rb_r;
                end
            end
        end
    end

    // Column output qualifiers follow the bank output register capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sel_r   <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (issue_s) begin
            out_valid_r <= 1'b1;
            out_sel_r   <= rb_r;
            out_last_r  <= (rcnt_r == LAST_IDX);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // A stalled bank keeps reloading its output register, so ra must repeat
    // the last issued column until the next issue presents the new one.
    assign ra             = issue_s ? rcnt_r : ra_r;
    assign wa             = wcnt_r;
    assign in_ready       = in_ready_s;
    assign ram0_din_valid = wr_s && !wb_r;
    assign ram1_din_valid = wr_s &&  wb_r;
    assign ram0_rnw       = ~state0_r[1];
    assign ram1_rnw       = ~state1_r[1];
    assign full_cnt       = {1'b0, state0_r[1]} + {1'b0, state1_r[1]};
    assign be             = 8'h00;
    assign out_valid      = out_valid_r;
    assign out_sel        = out_sel_r;
    assign out_last       = out_last_r;

endmodule

// File: tb/tb_tpose_pingpong_ctrl.sv
// Bench for tpose_pingpong_ctrl: behavioural transpose RAMs plus a column scoreboard.
module tb_tpose_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_sel;
    logic        ram0_rnw, ram1_rnw, ram0_din_valid, ram1_din_valid;
    logic [2:0]  wa, ra;
    logic [7:0]  be;
    logic [1:0]  full_cnt;
    logic [63:0] row_data;

    always #5 clk = ~clk;

    tpose_pingpong_ctrl #(.ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_sel(out_sel),
        .ram0_rnw(ram0_rnw), .ram1_rnw(ram1_rnw),
        .ram0_din_valid(ram0_din_valid), .ram1_din_valid(ram1_din_valid),
        .wa(wa), .ra(ra), .be(be), .full_cnt(full_cnt)
    );

    // Behavioural banks: row write in write mode, column capture in read mode
    logic [7:0][63:0] mem0, mem1;
    logic [63:0]      dout0, dout1;

    function automatic logic [63:0] col_of(input logic [7:0][63:0] m, input logic [2:0] k);
        logic [63:0] v;
        for (int j = 0; j < 8; j++) v[8*j +: 8] = m[j][8*k +: 8];
        return v;
    endfunction

    always @(posedge clk) begin
        if (ram0_rnw && ram0_din_valid) mem0[wa] <= row_data;
        if (!ram0_rnw) dout0 <= col_of(mem0, ra);
        if (ram1_rnw && ram1_din_valid) mem1[wa] <= row_data;
        if (!ram1_rnw) dout1 <= col_of(mem1, ra);
    end

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        sel;
    } exp_t;
    exp_t q[$];

    int         tests = 0, fails = 0;
    int         rows_goal, rows_acc, blk_rst, pops, cyc, t7, first_ov, ir_drops, ov_early;
    logic [1:0] tag = 2'd0;

    function automatic logic [63:0] row_val(input logic [1:0] t, input logic [2:0] r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[8*c +: 8] = {t, r, 3'(c)};
        return v;
    endfunction

    function automatic logic [63:0] exp_col(input logic [1:0] t, input logic [2:0] k);
        logic [63:0] v;
        for (int j = 0; j < 8; j++) v[8*j +: 8] = {t, 3'(j), k};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_in_ready",  64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last",  64'(out_last), 64'(0));
        chk("rst_out_sel",   64'(out_sel), 64'(0));
        chk("rst_rnw",       64'({ram1_rnw, ram0_rnw}), 64'(3));
        chk("rst_din_valid", 64'({ram1_din_valid, ram0_din_valid}), 64'(0));
        chk("rst_wa",        64'(wa), 64'(0));
        chk("rst_ra",        64'(ra), 64'(0));
        chk("rst_full_cnt",  64'(full_cnt), 64'(0));
        chk("rst_be",        64'(be), 64'(0));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        q.delete();
        rows_acc = 0; rows_goal = 0; blk_rst = 0; pops = 0;
        first_ov = -1; ir_drops = 0; ov_early = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, then account the handshakes of the coming edge
    task automatic step(input logic rdy);
        exp_t e;
        @(negedge clk);
        in_valid  = (rows_acc < rows_goal);
        row_data  = row_val(tag, rows_acc[2:0]);
        out_ready = rdy;
        #1;
        cyc++;
        if (in_valid && !in_ready) ir_drops++;
        if (out_valid && rows_acc < 8) ov_early++;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (in_valid && in_ready) begin
            chk("wa", 64'(wa), 64'(rows_acc % 8));
            chk("din_valid", 64'({ram1_din_valid, ram0_din_valid}), blk_rst[0] ? 64'(2) : 64'(1));
            if (rows_acc % 8 == 7) begin
                for (int k = 0; k < 8; k++) begin
                    e.data = exp_col(tag, 3'(k));
                    e.last = (k == 7);
                    e.sel  = blk_rst[0];
                    q.push_back(e);
                end
                t7  = cyc;
                tag = tag + 2'd1;
                blk_rst++;
            end
            rows_acc++;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_col", 64'(out_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("col_data", out_sel ? dout1 : dout0, e.data);
                chk("col_last", 64'(out_last), 64'(e.last));
                chk("col_sel",  64'(out_sel), 64'(e.sel));
                pops++;
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            if (rows_acc >= rows_goal && q.size() == 0) break;
            step(1'b1);
        end
        chk("drain_done", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; row_data = 64'd0; cyc = 0;

        // Single block with latency check
        do_reset();
        rows_goal = 8;
        drain();
        chk("single_pops", 64'(pops), 64'(8));
        chk("single_latency", 64'(first_ov - t7), 64'(2));

        // Streaming 32 rows: in_ready never drops, banks alternate
        do_reset();
        rows_goal = 32;
        drain();
        chk("stream_ir_drops", 64'(ir_drops), 64'(0));
        chk("stream_pops", 64'(pops), 64'(32));

        // Back-pressure at column 3
        do_reset();
        rows_goal = 8;
        for (int c = 0; c < 100; c++) begin
            if (pops == 3) break;
            step(1'b1);
        end
        chk("bp_reach_col3", 64'(pops), 64'(3));
        for (int s = 0; s < 5; s++) begin
            step(1'b0);
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_ra", 64'(ra), 64'(3));
            chk("bp_last", 64'(out_last), 64'(0));
            chk("bp_sel", 64'(out_sel), 64'(0));
            chk("bp_data", dout0, exp_col(tag - 2'd1, 3'd3));
        end
        step(1'b1);
        chk("bp_resume_ra", 64'(ra), 64'(4));
        drain();
        chk("bp_pops", 64'(pops), 64'(8));

        // Both banks full
        do_reset();
        rows_goal = 16;
        for (int c = 0; c < 100; c++) begin
            if (rows_acc == 16) break;
            step(1'b0);
        end
        step(1'b0);
        chk("both_in_ready", 64'(in_ready), 64'(0));
        chk("both_full_cnt", 64'(full_cnt), 64'(2));
        chk("both_rnw", 64'({ram1_rnw, ram0_rnw}), 64'(0));
        for (int c = 0; c < 100; c++) begin
            if (pops == 8) break;
            step(1'b1);
        end
        chk("free_in_ready", 64'(in_ready), 64'(1));
        chk("free_full_cnt", 64'(full_cnt), 64'(1));
        chk("free_rnw0", 64'(ram0_rnw), 64'(1));
        drain();

        // Reset mid-drain after column 4
        do_reset();
        rows_goal = 8;
        for (int c = 0; c < 100; c++) begin
            if (pops == 5) break;
            step(1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        q.delete();
        rows_acc = 0; rows_goal = 0; blk_rst = 0; pops = 0; first_ov = -1; ov_early = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) step(1'b1);
        rows_goal = 8;
        drain();
        chk("rmd_no_early_valid", 64'(ov_early), 64'(0));
        chk("rmd_latency", 64'(first_ov - t7), 64'(2));
        chk("rmd_pops", 64'(pops), 64'(8));

        // Row 7 of bank 1 and column 7 of bank 0 on the same edge
        do_reset();
        rows_goal = 16;
        for (int c = 0; c < 100; c++) begin
            if (rows_acc == 16) break;
            step(1'b1);
        end
        chk("sim_ra7", 64'(ra), 64'(7));
        chk("sim_sel0", 64'(out_sel), 64'(0));
        chk("sim_full_cnt_pre", 64'(full_cnt), 64'(1));
        step(1'b1);
        chk("sim_rnw", 64'({ram1_rnw, ram0_rnw}), 64'(1));
        chk("sim_full_cnt", 64'(full_cnt), 64'(1));
        chk("sim_ra0", 64'(ra), 64'(0));
        chk("sim_in_ready", 64'(in_ready), 64'(1));
        chk("sim_last_col7", 64'(out_last), 64'(1));
        drain();
        chk("sim_pops", 64'(pops), 64'(16));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tpose_pingpong_ctrl.md
# tpose_pingpong_ctrl

Sequencing controller for a pair of 8x8-byte row-write/column-read transpose RAM banks in the 2D-transform datapath. It accepts a stream of 64-bit rows, steers each group of 8 rows into the bank currently in write mode, then drains that bank as 8 transposed 64-bit columns while the other bank fills. It owns all bank control (rnw, din_valid, byte enables, write and read addresses) and the output select. The row data and column data do not pass through this block.

## Interface
- ADDR_W, 3: row/column index width. Bank depth is 2^ADDR_W = 8. Only 3 is supported.
- clk  in  1  single clock. Also drives the RAM write and read clocks.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream row available.
- in_ready  out  1  row accepted when in_valid && in_ready.
- out_valid  out  1  column word valid on the selected bank output.
- out_ready  in  1  downstream accepts column.
- out_last  out  1  the current column is column 7 of its block.
- out_sel  out  1  bank whose output carries the current column.
- ram0_rnw, ram1_rnw  out  1  per-bank mode: 1 = write mode (output held), 0 = read mode.
- ram0_din_valid, ram1_din_valid  out  1  per-bank write strobe.
- wa  out  ADDR_W  shared row write address.
- ra  out  ADDR_W  shared column read address.
- be  out  8  active-low byte enables, constant 8'h00.
- full_cnt  out  2  number of banks in FULL or DRAIN (0..2).

## Operation
- Each bank has its own 2-bit state, all transitions on the clk edge:
  - EMPTY -> FILL on the first write.
  - FILL -> FULL on the write of row 7.
  - FULL -> DRAIN on issue of column 0.
  - DRAIN -> EMPTY on issue of column 7.
- Pointers:
  - wb = write bank, toggles when a bank reaches FULL.
  - rb = read bank, toggles when a bank returns to EMPTY.
  - wcnt, rcnt are 3-bit counters that wrap 7->0 when a block completes.
- in_ready = state[wb] is EMPTY or FILL. Combinational from state only, never from in_valid.
- Write strobe: ramX_din_valid = in_valid && in_ready && (wb==X). wa = wcnt.
- Bank mode: ramX_rnw = 0 only while bank X is FULL or DRAIN, otherwise 1.
- Column issue: issue = state[rb] is FULL or DRAIN, and (!out_valid || out_ready).
  - On issue, ra presents rcnt for that cycle and the bank output register captures the column at the edge.
  - On that same edge: out_valid <= 1, out_sel <= rb, out_last <= (rcnt==7), rcnt increments.
- Without issue: if out_valid && out_ready, out_valid <= 0.
- Stall: ra holds its last issued value, so a bank still in read mode keeps reloading the same column and its output stays stable.
- After column 7 the bank goes EMPTY and rnw returns to 1. The bank output then holds, so the final column stays valid while the bank is rewritten.
- Write and read never target the same bank in the same cycle.
- Both banks FULL/DRAIN: in_ready = 0.
- Both banks EMPTY: no issue.
- full_cnt counts banks in FULL or DRAIN.

## Timing
- Reset values:
  - Both banks EMPTY, wb = rb = 0, wcnt = rcnt = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, out_sel = 0.
  - ram0_rnw = ram1_rnw = 1, din_valid both 0, wa = ra = 0, full_cnt = 0.
- Reset asserted mid-fill or mid-drain aborts the block. Partial data is discarded and no out_valid appears after release until 8 new rows are accepted.
- Latency: row 7 accepted in cycle T -> bank FULL and column 0 issued in T+1 -> out_valid = 1 in T+2.
- Throughput: 1 row/cycle in and 1 column/cycle out sustained. Continuous input with out_ready = 1 never deasserts in_ready.
- Back-pressure: out_valid, out_sel, out_last and ra stay constant while out_valid && !out_ready.
- Row 7 write and column-7 issue of the other bank in the same cycle: both state changes and both pointer toggles apply on that edge.

## Test plan
- Single block: 8 rows, row r byte c = {r,c}, out_ready = 1 -> 8 columns. Column k byte j = {j,k}. out_valid first seen 2 cycles after row 7. out_last only on column 7. out_sel = 0.
- Streaming: 32 rows back-to-back with out_ready = 1 -> in_ready never drops. 32 columns out. out_sel sequence 0,1,0,1 per block.
- Back-pressure: out_ready = 0 for 5 cycles at column 3 -> column 3 is held with ra = 3. Resumes with column 4 the cycle after out_ready returns.
- Both full: 16 rows with out_ready = 0 -> in_ready = 0 after row 15. full_cnt = 2. Freeing bank 0 (8 reads) restores in_ready.
- Reset mid-drain: rst_n low after column 4 -> all outputs at reset values immediately. After release, no out_valid until 8 new rows are accepted.
- Simultaneous events: row 7 of bank 1 accepted in the same cycle column 7 of bank 0 issues -> next cycle bank 0 EMPTY/write mode, bank 1 FULL, column 0 of bank 1 issued.
